// File: rtl/rst_cipher_pkg.sv
// Shared constants and helpers for the RST cipher blocks: character codes,
// key/table geometry, header index maps and the fixed interior alphabet.
package rst_cipher_pkg;

  localparam int KEY_LEN   = 12;
  localparam int TABLE_DIM = 7;
  localparam int HDR_LEN   = TABLE_DIM - 1;
  localparam int ALPHA_LEN = 26;

  localparam logic [7:0] NUL_CHAR         = 8'h00;
  localparam logic [7:0] UPPERCASE_A_CHAR = 8'h41;
  localparam logic [7:0] UPPERCASE_Z_CHAR = 8'h5A;
  localparam logic [7:0] LOWERCASE_A_CHAR = 8'h61;
  localparam logic [7:0] LOWERCASE_Z_CHAR = 8'h7A;
  localparam logic [7:0] DIGIT_0_CHAR     = 8'h30;
  localparam logic [7:0] DIGIT_9_CHAR     = 8'h39;

  // Key character feeding header row/column position 1..6 (index 0 = position 1).
  localparam int unsigned ROW_KEY_IDX [HDR_LEN] = '{0, 10, 2, 8, 4, 6};
  localparam int unsigned COL_KEY_IDX [HDR_LEN] = '{1, 11, 3, 9, 5, 7};

  typedef struct packed {
    logic repeated;
    logic invalid;
  } key_err_t;

  function automatic logic is_key_char(input logic [7:0] ch);
    return ((ch >= UPPERCASE_A_CHAR) && (ch <= UPPERCASE_Z_CHAR)) ||
           ((ch >= LOWERCASE_A_CHAR) && (ch <= LOWERCASE_Z_CHAR)) ||
           ((ch >= DIGIT_0_CHAR)     && (ch <= DIGIT_9_CHAR));
  endfunction

  function automatic logic [7:0] key_byte(input logic [8*KEY_LEN-1:0] key,
                                          input int unsigned idx);
    return key[8*idx +: 8];
  endfunction

  // Interior cell at row-major position 0..35: 'a'..'z' then '0'..'9'.
  function automatic logic [7:0] interior_char(input int unsigned pos);
    if (pos < ALPHA_LEN) return LOWERCASE_A_CHAR + 8'(pos);
    else                 return DIGIT_0_CHAR + 8'(pos - ALPHA_LEN);
  endfunction

endpackage

// File: rtl/key_char_check.sv
// Combinational key validation: flags any non-alphanumeric character and any
// exact (case-sensitive) duplicate among the twelve key characters.
module key_char_check
  import rst_cipher_pkg::*;
(
  input  logic [8*KEY_LEN-1:0] i_key_char,
  output logic                 o_err_repeated,
  output logic                 o_err_invalid
);

  logic [KEY_LEN-1:0] w_char_bad;
  logic [KEY_LEN-1:0] w_char_dup;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    w_char_bad = '0;
    w_char_dup = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      w_char_bad[i] = !is_key_char(key_byte(i_key_char, i));
      for (int j = i + 1; j < KEY_LEN; j++) begin
        if (key_byte(i_key_char, i) == key_byte(i_key_char, j)) w_char_dup[i] = 1'b1;
      end
    end
  end

  assign o_err_invalid  = |w_char_bad;
  assign o_err_repeated = |w_char_dup;

endmodule

// File: rtl/init_table.sv
// Builds the registered 7x7 RST substitution table from a 12-character key;
// any key error blanks the whole table to NUL while the flags report why.
module init_table
  import rst_cipher_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [8*KEY_LEN-1:0]                     key_char,
  output logic [TABLE_DIM-1:0][TABLE_DIM-1:0][7:0] sub_char,
  output logic                                     err_repeated_char,
  output logic                                     err_invalid_key_char
);

  key_err_t                                w_err;
  logic                                    w_key_ok;
  logic [TABLE_DIM-1:0][TABLE_DIM-1:0][7:0] w_table;

  logic [TABLE_DIM-1:0][TABLE_DIM-1:0][7:0] r_sub_char;
  key_err_t                                r_err;

  key_char_check u_key_char_check (
    .i_key_char     (key_char),
    .o_err_repeated (w_err.repeated),
    .o_err_invalid  (w_err.invalid)
  );

  assign w_key_ok = !(w_err.repeated || w_err.invalid);

  // Corner stays NUL; headers come from the key, interior is the fixed alphabet.
  always_comb begin
    w_table = '0;
    if (w_key_ok) begin
      w_table[0][0] = NUL_CHAR;
      for (int r = 1; r < TABLE_DIM; r++) begin
        w_table[r][0] = key_byte(key_char, ROW_KEY_IDX[r-1]);
      end
      for (int c = 1; c < TABLE_DIM; c++) begin
        w_table[0][c] = key_byte(key_char, COL_KEY_IDX[c-1]);
      end
      for (int r = 1; r < TABLE_DIM; r++) begin
        for (int c = 1; c < TABLE_DIM; c++) begin
          w_table[r][c] = interior_char(unsigned'((r - 1) * HDR_LEN + (c - 1)));
        end
      end
    end
  end

  // rst_n is active-high here despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      // NOTE: this is a flop bank feeding outputs directly, not a RAM, so
      // every entry is reset; a true memory array would be left unreset.
      r_sub_char <= '0;
      r_err      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values, whatever the statement order.
      r_sub_char <= w_table;
      r_err      <= w_err;
    end
  end

  assign sub_char             = r_sub_char;
  assign err_repeated_char    = r_err.repeated;
  assign err_invalid_key_char = r_err.invalid;

endmodule

// File: tb/tb_init_table.sv
// Self-checking bench for init_table: a reference model pushes the expected
// table/flags when a key is driven; a monitor pops and compares one edge later.
module tb_init_table;

  typedef struct {
    logic [6:0][6:0][7:0] tbl;
    logic                 rep;
    logic                 inv;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [95:0]          key_char;
  logic [6:0][6:0][7:0] sub_char;
  logic                 err_repeated_char;
  logic                 err_invalid_key_char;

  int   n_checks;
  int   n_pass;
  exp_t q[$];

  init_table dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .key_char             (key_char),
    .sub_char             (sub_char),
    .err_repeated_char    (err_repeated_char),
    .err_invalid_key_char (err_invalid_key_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [95:0] k);
    exp_t  e;
    byte   c [12];
    string alpha;
    int    rmap [6];
    int    cmap [6];
    alpha = "abcdefghijklmnopqrstuvwxyz0123456789";
    rmap  = '{0, 10, 2, 8, 4, 6};
    cmap  = '{1, 11, 3, 9, 5, 7};
    e.tbl = '0;
    e.rep = 1'b0;
    e.inv = 1'b0;
    for (int i = 0; i < 12; i++) c[i] = k[8*i +: 8];
    for (int i = 0; i < 12; i++) begin
      if (!((c[i] >= "A" && c[i] <= "Z") || (c[i] >= "a" && c[i] <= "z") ||
            (c[i] >= "0" && c[i] <= "9"))) e.inv = 1'b1;
      for (int j = 0; j < 12; j++)
        if (i != j && c[i] == c[j]) e.rep = 1'b1;
    end
    if (!e.rep && !e.inv) begin
      for (int r = 1; r < 7; r++) e.tbl[r][0] = c[rmap[r-1]];
      for (int cc = 1; cc < 7; cc++) e.tbl[0][cc] = c[cmap[cc-1]];
      for (int r = 1; r < 7; r++)
        for (int cc = 1; cc < 7; cc++) e.tbl[r][cc] = alpha[(r-1)*6 + cc-1];
    end
    return e;
  endfunction

  // Scoreboard monitor: one expected entry per driven key, checked #1 after the next edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      for (int r = 0; r < 7; r++)
        check($sformatf("row%0d", r), 64'(sub_char[r]), 64'(e.tbl[r]));
      check("err_repeated", 64'(err_repeated_char), 64'(e.rep));
      check("err_invalid", 64'(err_invalid_key_char), 64'(e.inv));
    end
  end

  task automatic drive(input logic [95:0] k);
    @(negedge clk);
    key_char = k;
    q.push_back(model(k));
  endtask

  task automatic drive_flags(input string tag, input logic [95:0] k,
                             input logic rep, input logic inv);
    drive(k);
    @(posedge clk);
    #1;
    check({tag, "_rep"}, 64'(err_repeated_char), 64'(rep));
    check({tag, "_inv"}, 64'(err_invalid_key_char), 64'(inv));
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 7; r++)
      check($sformatf("%s_row%0d", tag, r), 64'(sub_char[r]), 64'd0);
    check({tag, "_rep"}, 64'(err_repeated_char), 64'd0);
    check({tag, "_inv"}, 64'(err_invalid_key_char), 64'd0);
  endtask

  initial begin
    logic [95:0] k_valid;
    logic [95:0] k;
    string       col_exp;
    string       row_exp;
    string       pool;
    logic [7:0]  bnd_bad [6];
    logic [7:0]  bnd_ok  [5];

    n_checks = 0;
    n_pass   = 0;
    k_valid  = "abcdefghilmn";
    col_exp  = "nblqhf";
    col_exp  = "nbldhf";
    row_exp  = "maicge";
    pool     = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
    bnd_bad  = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h2F, 8'h3A};
    bnd_ok   = '{8'h41, 8'h5A, 8'h30, 8'h39, 8'h7A};

    rst_n    = 1'b1;
    key_char = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Release reset with the valid key loaded: first edge must show the table.
    @(negedge clk);
    key_char = k_valid;
    q.push_back(model(k_valid));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("corner", 64'(sub_char[0][0]), 64'h00);
    for (int i = 1; i < 7; i++) begin
      check($sformatf("col0_r%0d", i), 64'(sub_char[i][0]), 64'(col_exp[i-1]));
      check($sformatf("row0_c%0d", i), 64'(sub_char[0][i]), 64'(row_exp[i-1]));
    end
    check("a_1_1", 64'(sub_char[1][1]), 64'h61);
    check("z_5_2", 64'(sub_char[5][2]), 64'h7A);
    check("0_5_3", 64'(sub_char[5][3]), 64'h30);
    check("9_6_6", 64'(sub_char[6][6]), 64'h39);

    drive_flags("dup_adj",   "abcdefghilma", 1'b1, 1'b0);
    check_all_zero_tbl: for (int r = 0; r < 7; r++)
      check($sformatf("dup_row%0d", r), 64'(sub_char[r]), 64'd0);
    drive_flags("dup_far",   "aBcdefghijkB", 1'b1, 1'b0);
    drive_flags("case",      "aAbcdefghijk", 1'b0, 1'b0);
    drive_flags("bang",      "abcdefghilm!", 1'b0, 1'b1);
    drive_flags("both",      "abcdefghil!!", 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      k = {bnd_bad[i], k_valid[87:0]};
      drive_flags($sformatf("bnd_bad%0d", i), k, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      k = {bnd_ok[i], k_valid[87:0]};
      drive_flags($sformatf("bnd_ok%0d", i), k, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges while a valid table is shown.
    drive(k_valid);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    q.push_back(model(key_char));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("restore_a", 64'(sub_char[1][1]), 64'h61);

    // Back-to-back valid -> invalid -> valid, one key per cycle.
    drive("abcdefghilmn");
    drive("abcdefghilm!");
    drive("zyxwvuts9876");
    drive("ZYXWVUTSRQPA");
    drive("ZYXWVUTSRQPZ");
    drive("0123456789Ab");

    // Random keys, mostly legal characters, some out-of-set bytes.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(19) == 0) k[8*i +: 8] = 8'($urandom_range(255));
        else k[8*i +: 8] = pool[$urandom_range(61)];
      end
      drive(k);
    end

    for (int n = 0; n < 10 && q.size() != 0; n++) @(posedge clk);
    #2;
    check("drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/init_table.md
# init_table

Builds the 7×7 substitution table for the RST cipher from a 12-character key. Row 0 and column 0 are key-derived headers; the 6×6 interior is the fixed alphabet 'a'–'z' followed by '0'–'9'. The block also validates the key and sits between key loading and the encrypt/decrypt datapath, which reads `sub_char`.

## Interface
- No parameters.
- `clk`  in  1  single clock; rising-edge active.
- `rst_n`  in  1  asynchronous reset, **active-high**: asserted when 1, despite the `_n` suffix.
- `key_char`  in  96  key; character k[i] = `key_char[8i+7:8i]`, i = 0..11, so k0 is the LSB byte.
- `sub_char`  out  [7][7] × 8  substitution table, indexed `[row][col]`.
- `err_repeated_char`  out  1  key contains a duplicate character.
- `err_invalid_key_char`  out  1  key contains a character that is not a letter or digit.

## Operation
- **Valid character:** 'A'–'Z' (0x41–0x5A), 'a'–'z' (0x61–0x7A), or '0'–'9' (0x30–0x39).
- **`err_invalid_key_char`** = 1 if any of k0..k11 is not a valid character.
- **`err_repeated_char`** = 1 if any two of k0..k11 are byte-equal. Comparison is exact and case-sensitive, over all 66 pairs.
- **Valid key** (no error flag set):
  - `sub_char[0][0]` = 0x00 (NUL).
  - Column 0, rows 1..6 = k0, k10, k2, k8, k4, k6.
  - Row 0, cols 1..6 = k1, k11, k3, k9, k5, k7.
  - Interior rows 1..6, cols 1..6, filled row-major: positions 0..25 = 'a'..'z', positions 26..35 = '0'..'9'.
  - Resulting anchors: [1][1]='a', [5][2]='z', [5][3]='0', [6][6]='9'.
- **Either error set:** all 49 `sub_char` entries = 0x00. Both flags are computed and reported independently, and both may be 1 at once.
- **Interior values:** constant, but they are registered and gated by the error condition, like the headers.

## Timing
- All outputs are registered, with a single register stage.
- `key_char` is sampled on each rising `clk`. Outputs reflect that sample after the same edge, so latency is 1 cycle.
- No handshake. The key is re-evaluated every cycle, and outputs track the key continuously with 1-cycle lag.
- Reset (`rst_n`=1, asynchronous):
  - all `sub_char` entries = 0x00;
  - both error flags = 0.
- Reset is held while `rst_n`=1. The first valid output appears at the first rising edge after deassertion.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge.
- Key change at edge N: the outputs at edge N show the new table/flags in full. No mixed old/new state is permitted.

## Structure
- Shared package `rst_cipher_pkg` holds:
  - character constants: `NUL_CHAR`, `UPPERCASE_A_CHAR`, `UPPERCASE_Z_CHAR`, `LOWERCASE_A_CHAR`, `LOWERCASE_Z_CHAR`, `DIGIT_0_CHAR`, `DIGIT_9_CHAR`;
  - `KEY_LEN` = 12 and `TABLE_DIM` = 7;
  - the header index maps: `ROW_KEY_IDX` = {0,10,2,8,4,6} and `COL_KEY_IDX` = {1,11,3,9,5,7}.
- Sub-module `key_char_check`, combinational. It takes the 96-bit key and produces the two raw error bits: per-character validity plus the pairwise duplicate compare.
- `init_table` contains:
  - the header/interior assembly, combinational;
  - the output register bank with asynchronous reset.

## Test plan
- **Valid key:** reset, then `key_char` = "abcdefghilmn" (k0='n', k11='a').
  - After 1 edge: column 0 rows 1..6 = n,b,l,d,h,f; row 0 cols 1..6 = m,a,i,c,g,e.
  - [0][0]=0x00, [1][1]='a', [5][2]='z', [5][3]='0', [6][6]='9'; both flags 0.
- **Duplicate:** "abcdefghilma" → `err_repeated_char`=1, `err_invalid_key_char`=0, all entries 0x00.
- **Non-adjacent duplicate plus case:**
  - "aBcdefghijkB" → `err_repeated_char`=1.
  - "aAbcdefghijk" → both flags 0, since the compare is case-sensitive.
- **Invalid character:** "abcdefghilm!" → `err_invalid_key_char`=1, table all 0x00. Also test boundary characters 0x40, 0x5B, 0x60, 0x7B, 0x2F and 0x3A individually → flag 1.
- **Reset behaviour:**
  - Assert `rst_n`=1 asynchronously between edges while a valid table is shown → all outputs 0 immediately.
  - After deassertion, the next edge restores the table.
- **Back-to-back key changes:** valid → invalid → valid on consecutive cycles → outputs follow with exactly 1-cycle latency and no stale entries.
